// File: rtl/state_pkg.sv
// Shared game and board-link types: game state encoding, link frame layout and transmitter FSM states.
package state_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        LEVEL_1 = 2'd1,
        FINISH  = 2'd2
    } g_state;

    localparam int LINK_DATA_BITS  = 16;
    localparam int LINK_XPOS_LSB   = 0;
    localparam int LINK_STATE_LSB  = 12;
    localparam int LINK_START_BIT  = 14;
    localparam int LINK_PARITY_BIT = 15;

    typedef struct packed {
        logic        parity;
        logic        start_req;
        g_state      state;
        logic [11:0] xpos;
    } link_frame_t;

    // Transmitter states carry a TX_ prefix so they do not collide with g_state::START.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    // Even parity: total number of ones across all 16 bits comes out even.
    function automatic link_frame_t pack_frame(input logic [11:0] xpos, input g_state st,
                                               input logic start_req);
        link_frame_t f;
        f.xpos      = xpos;
        f.state     = st;
        f.start_req = start_req;
        f.parity    = ^{start_req, st, xpos};
        return f;
    endfunction

endpackage

// File: rtl/link_baud_tick.sv
// Bit-period timer for the GPIO link: pulses bit_tick on the last clock of each bit period.
module link_baud_tick #(
    parameter int CLK_DIV = 40
) (
    input  logic clk_40,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bit_tick = run && (cnt_q == LAST);
        cnt_d    = cnt_q + CW'(1);
        if (!run || bit_tick) cnt_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_40) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/player_link_tx.sv
// Board-to-board link transmitter: idle-high line, start bit, 16 data bits LSB first, stop bit, idle gap.
module player_link_tx
    import state_pkg::*;
#(
    parameter int CLK_DIV   = 40,
    parameter int FRAME_GAP = 16
) (
    input  logic        clk_40,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [11:0] xpos_player,
    input  g_state      game_state,
    input  logic        start_req,
    output logic        gpio_tx,
    output logic        busy
);

    localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
    localparam logic [GW-1:0] LAST_GAP = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam logic [3:0]    LAST_BIT = 4'(LINK_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic [LINK_DATA_BITS-1:0] word_q, word_d;
    logic                      gpio_q, gpio_d;
    logic                      bit_tick;

    link_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk_40   (clk_40),
        .rst      (rst),
        .run      (state_q != TX_IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        word_d    = word_q;
        case (state_q)
            TX_IDLE: if (tx_valid) begin
                word_d  = pack_frame(xpos_player, game_state, start_req);
                state_d = TX_START;
            end
            TX_START: if (bit_tick) begin
                bit_idx_d = '0;
                state_d   = TX_DATA;
            end
            TX_DATA: if (bit_tick) begin
                if (bit_idx_q == LAST_BIT) state_d = TX_STOP;
                else                       bit_idx_d = bit_idx_q + 4'd1;
            end
            TX_STOP: if (bit_tick) begin
                gap_cnt_d = '0;
                state_d   = (FRAME_GAP == 0) ? TX_IDLE : TX_GAP;
            end
            TX_GAP: if (bit_tick) begin
                if (gap_cnt_q == LAST_GAP) state_d = TX_IDLE;
                else                       gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the next state so it changes on the same edge as the FSM.
        case (state_d)
            TX_START: gpio_d = 1'b0;
            TX_DATA:  gpio_d = word_q[bit_idx_d];
            default:  gpio_d = 1'b1;
        endcase
    end

    // NOTE: the latched word is reset too; it is a single register, not a memory, so the cost is trivial.
    always_ff @(posedge clk_40) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            word_q    <= '0;
            gpio_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            word_q    <= word_d;
            gpio_q    <= gpio_d;
        end
    end

    assign gpio_tx  = gpio_q;
    assign tx_ready = (state_q == TX_IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_player_link_tx.sv
// Directed bench for player_link_tx with CLK_DIV=4, FRAME_GAP=2 (81-cycle frame including the idle gap).
module tb_player_link_tx;
    import state_pkg::*;

    logic        clk_40 = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        start_req = 1'b0;
    logic [11:0] xpos_player = '0;
    g_state      game_state = START;
    logic        tx_ready, gpio_tx, busy;

    int checks = 0;
    int errors = 0;

    player_link_tx #(.CLK_DIV(4), .FRAME_GAP(2)) dut (
        .clk_40      (clk_40),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .xpos_player (xpos_player),
        .game_state  (game_state),
        .start_req   (start_req),
        .gpio_tx     (gpio_tx),
        .busy        (busy)
    );

    always #5 clk_40 = ~clk_40;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Line value sampled at edge k after accept at edge 0: start 1-4, bit i 5+4i..8+4i, stop/gap/idle after.
    function automatic logic [81:1] exp_line(input logic [15:0] w);
        logic [81:1] l;
        for (int k = 1; k <= 81; k++) begin
            if (k <= 4)       l[k] = 1'b0;
            else if (k <= 68) l[k] = w[(k - 5) / 4];
            else              l[k] = 1'b1;
        end
        return l;
    endfunction

    function automatic logic [81:1] exp_ready();
        logic [81:1] r;
        r     = '0;
        r[81] = 1'b1;
        return r;
    endfunction

    // Receiver model: samples each data bit in the middle of its bit period.
    function automatic logic [15:0] decode_word(input logic [81:1] l);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = l[5 + 4 * i + 2];
        return w;
    endfunction

    // Caller sets inputs and tx_valid at a negedge; accept edge follows. Mode 0 drops valid,
    // mode 1 also pokes valid/inputs mid-frame, mode 2 keeps valid high.
    task automatic capture(input int mode, output logic [81:1] line,
                           output logic [81:1] rdy, output logic [81:1] bsy);
        @(posedge clk_40);
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk_40);
            line[k] = gpio_tx;
            rdy[k]  = tx_ready;
            bsy[k]  = busy;
            if (mode != 2) tx_valid = 1'b0;
            if (mode == 1) begin
                if (k == 10 || k == 40) tx_valid = 1'b1;
                if (k == 20) begin
                    xpos_player = 12'h555;
                    game_state  = FINISH;
                    start_req   = 1'b1;
                end
            end
        end
    endtask

    task automatic set_inputs(input logic [11:0] x, input g_state st, input logic s);
        xpos_player = x;
        game_state  = st;
        start_req   = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_40);
        @(negedge clk_40);
        checks++;
        if (gpio_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_gpio: got %b expected 1", gpio_tx);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", tx_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_40);
            checks++;
            if (gpio_tx !== 1'b1 || tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_line cycle %0d: gpio %b ready %b expected 1 1", c, gpio_tx, tx_ready);
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [11:0] x, input g_state st,
                              input logic s, input logic [15:0] w);
        logic [81:1] line, rdy, bsy;
        set_inputs(x, st, s);
        tx_valid = 1'b1;
        capture(0, line, rdy, bsy);
        checks++;
        if (line !== exp_line(w)) begin
            errors++;
            $display("FAIL %s_line: got %h expected %h", name, line, exp_line(w));
        end
        checks++;
        if (rdy !== exp_ready()) begin
            errors++;
            $display("FAIL %s_ready: got %h expected %h", name, rdy, exp_ready());
        end
        checks++;
        if (bsy !== ~exp_ready()) begin
            errors++;
            $display("FAIL %s_busy: got %h expected %h", name, bsy, ~exp_ready());
        end
        checks++;
        if (decode_word(line) !== w) begin
            errors++;
            $display("FAIL %s_decode: got %h expected %h", name, decode_word(line), w);
        end
    endtask

    task automatic test_ignore_during_frame();
        logic [81:1] line, rdy, bsy;
        set_inputs(12'h2BC, LEVEL_1, 1'b0);
        tx_valid = 1'b1;
        capture(1, line, rdy, bsy);
        checks++;
        if (line !== exp_line(16'h92BC)) begin
            errors++;
            $display("FAIL ignore_line: got %h expected %h", line, exp_line(16'h92BC));
        end
        checks++;
        if (rdy !== exp_ready()) begin
            errors++;
            $display("FAIL ignore_ready: got %h expected %h", rdy, exp_ready());
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_40);
            checks++;
            if (gpio_tx !== 1'b1 || tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL ignore_no_queue cycle %0d: gpio %b ready %b expected 1 1", c, gpio_tx, tx_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [81:1] l1, r1, b1, l2, r2, b2;
        set_inputs(12'h2BC, LEVEL_1, 1'b0);
        tx_valid = 1'b1;
        capture(2, l1, r1, b1);
        capture(0, l2, r2, b2);
        checks++;
        if (l1 !== exp_line(16'h92BC)) begin
            errors++;
            $display("FAIL b2b_line1: got %h expected %h", l1, exp_line(16'h92BC));
        end
        checks++;
        if (r1 !== exp_ready()) begin
            errors++;
            $display("FAIL b2b_ready1: got %h expected %h", r1, exp_ready());
        end
        checks++;
        if (l2 !== exp_line(16'h92BC)) begin
            errors++;
            $display("FAIL b2b_line2: got %h expected %h", l2, exp_line(16'h92BC));
        end
        checks++;
        if (decode_word(l1) !== 16'h92BC || decode_word(l2) !== 16'h92BC) begin
            errors++;
            $display("FAIL b2b_decode: got %h %h expected 92bc 92bc", decode_word(l1), decode_word(l2));
        end
    endtask

    task automatic test_reset_mid_frame();
        set_inputs(12'h2BC, LEVEL_1, 1'b0);
        tx_valid = 1'b1;
        @(posedge clk_40);
        for (int k = 1; k < 30; k++) begin
            @(negedge clk_40);
            tx_valid = 1'b0;
        end
        @(negedge clk_40);
        checks++;
        if (gpio_tx !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre_bit6: got %b expected 0", gpio_tx);
        end
        rst = 1'b1;
        @(negedge clk_40);
        checks++;
        if (gpio_tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: gpio %b ready %b busy %b expected 1 1 0", gpio_tx, tx_ready, busy);
        end
        rst = 1'b0;
        test_frame("after_reset", 12'hFFF, START, 1'b1, 16'hCFFF);
    endtask

    initial begin
        test_reset();
        test_frame("xpos700", 12'h2BC, LEVEL_1, 1'b0, 16'h92BC);
        test_frame("zero", 12'h000, START, 1'b0, 16'h0000);
        test_frame("ones", 12'hFFF, START, 1'b1, 16'hCFFF);
        test_ignore_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
